// File: rtl/huff_code_pack.sv
// Purpose:   Huffman encode stage; looks up per-symbol code length/bits in the table RAM and packs codes MSB-first into bytes.
// Latency:   8 cycles per symbol (GET_SYM..APPEND), +1 per emitted byte; flush byte and done pulse follow the last symbol.
// Backpress: out_valid/out_data held until out_ready; while blocked no table read is issued and src_ready stays low.
//
// Ports:
//   clk, reset (async, active-low)
//   encode_start          run start pulse, honoured only in IDLE
//   src_valid/src_ready   source symbol handshake, src_data (0..127 legal), src_last marks final symbol
//   tbl_addr/tbl_rd       registered table RAM read request; tbl_data sampled in the CAP state
//   out_valid/out_ready   packed byte stream, out_data holds first code bit in bit 7
//   encode_done           1-cycle end-of-run pulse; bit_count valid alongside it
//   err_sym               sticky illegal symbol / illegal code length flag, cleared by encode_start
module huff_code_pack #(
  parameter int CNT_W     = 16,
  parameter int CODE_BASE = 128,
  parameter int MAX_LEN   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             encode_start,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  input  logic             src_last,
  output logic             src_ready,
  output logic [9:0]       tbl_addr,
  output logic             tbl_rd,
  input  logic [7:0]       tbl_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             encode_done,
  output logic [CNT_W-1:0] bit_count,
  output logic             err_sym
);

  typedef enum logic [3:0] {
    IDLE, GET_SYM,
    LEN_RD, LEN_WAIT, LEN_CAP,
    CODE_RD, CODE_WAIT, CODE_CAP,
    APPEND, EMIT, FLUSH, DONE
  } state_t;

  state_t      state, next_state;
  logic [6:0]  sym;
  logic        last;
  logic [3:0]  len;
  logic [7:0]  code;
  logic [15:0] acc;
  logic [4:0]  fill;

  logic        bad_len;
  logic [4:0]  fill_sum;
  logic [7:0]  code_mask;
  logic [15:0] code_shifted;

  // Length check runs directly on the RAM data so LEN_CAP can branch in the same cycle.
  assign bad_len  = (tbl_data[3:0] == 4'd0) || (tbl_data[3:0] > 4'(MAX_LEN));
  assign fill_sum = fill + {1'b0, len};

  // Keep only the top len bits of the table entry; stray low bits must not leak into the stream.
  assign code_mask    = 8'hFF << (4'd8 - len);
  assign code_shifted = {code & code_mask, 8'h00} >> fill;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (encode_start) next_state = GET_SYM;
      GET_SYM: begin
        if (src_valid) begin
          if (src_data[7]) next_state = src_last ? FLUSH : GET_SYM;
          else             next_state = LEN_RD;
        end
      end
      LEN_RD:    next_state = LEN_WAIT;
      LEN_WAIT:  next_state = LEN_CAP;
      LEN_CAP: begin
        if (bad_len) next_state = last ? FLUSH : GET_SYM;
        else         next_state = CODE_RD;
      end
      CODE_RD:   next_state = CODE_WAIT;
      CODE_WAIT: next_state = CODE_CAP;
      CODE_CAP:  next_state = APPEND;
      APPEND: begin
        if (fill_sum >= 5'd8) next_state = EMIT;
        else                  next_state = last ? FLUSH : GET_SYM;
      end
      // fill never exceeds 15, so one byte always brings it below 8.
      EMIT:      if (out_ready) next_state = last ? FLUSH : GET_SYM;
      FLUSH:     if (fill == 5'd0 || out_ready) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    src_ready   = (state == GET_SYM);
    out_valid   = (state == EMIT) || ((state == FLUSH) && (fill != 5'd0));
    out_data    = out_valid ? acc[15:8] : 8'h00;
    encode_done = (state == DONE);
  end

  // Table read request is registered off next_state so it is already valid in RD and WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_rd   <= 1'b0;
      tbl_addr <= 10'd0;
    end else begin
      tbl_rd <= (next_state == LEN_RD)  || (next_state == LEN_WAIT) ||
                (next_state == CODE_RD) || (next_state == CODE_WAIT);
      case (next_state)
        LEN_RD:              tbl_addr <= {3'b000, src_data[6:0]};
        CODE_RD:             tbl_addr <= 10'(CODE_BASE) + {3'b000, sym};
        LEN_WAIT, CODE_WAIT: tbl_addr <= tbl_addr;
        default:             tbl_addr <= 10'd0;
      endcase
    end
  end

  // Datapath: symbol context, accumulator, counters and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym       <= 7'd0;
      last      <= 1'b0;
      len       <= 4'd0;
      code      <= 8'd0;
      acc       <= 16'd0;
      fill      <= 5'd0;
      bit_count <= '0;
      err_sym   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (encode_start) begin
            acc       <= 16'd0;
            fill      <= 5'd0;
            bit_count <= '0;
            err_sym   <= 1'b0;
          end
        end
        GET_SYM: begin
          if (src_valid) begin
            sym  <= src_data[6:0];
            last <= src_last;
            if (src_data[7]) err_sym <= 1'b1;
          end
        end
        LEN_CAP: begin
          len <= tbl_data[3:0];
          if (bad_len) err_sym <= 1'b1;
        end
        CODE_CAP: code <= tbl_data;
        APPEND: begin
          acc       <= acc | code_shifted;
          fill      <= fill_sum;
          bit_count <= bit_count + CNT_W'(len);
        end
        EMIT: begin
          if (out_ready) begin
            acc  <= acc << 8;
            fill <= fill - 5'd8;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_code_pack.sv
// Purpose:   Directed bench for huff_code_pack with a registered-read table RAM model.
// Latency:   Each run waits on encode_done under a cycle budget.
// Backpress: One run holds out_ready low for 10 cycles on the first byte.
module tb_huff_code_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        encode_start;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_last;
  logic        src_ready;
  logic [9:0]  tbl_addr;
  logic        tbl_rd;
  logic [7:0]  tbl_data = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        encode_done;
  logic [15:0] bit_count;
  logic        err_sym;

  huff_code_pack dut (
    .clk(clk), .reset(reset), .encode_start(encode_start),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .tbl_addr(tbl_addr), .tbl_rd(tbl_rd), .tbl_data(tbl_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .encode_done(encode_done), .bit_count(bit_count), .err_sym(err_sym)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) if (tbl_rd) tbl_data <= mem[tbl_addr];

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] syms [4];
  logic [7:0] got_q [$];
  logic       done_seen;
  logic [15:0] done_cnt;
  int         done_cyc;
  int         last_acc;
  logic       stable_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      src_valid = 1'b1;
      src_data  = syms[i];
      src_last  = (i == n - 1);
      while (!src_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("feed_ready", 32'(src_ready), 32'd1);
      @(negedge clk);
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = 8'h00;
  endtask

  task automatic collect(input int hold);
    int t;
    int hold_left;
    logic [7:0] held;
    t = 0;
    hold_left = hold;
    held = 8'h00;
    done_seen = 1'b0;
    stable_ok = 1'b1;
    last_acc = 0;
    while (!done_seen && t < 3000) begin
      @(negedge clk);
      t++;
      if (encode_done) begin
        done_seen = 1'b1;
        done_cnt  = bit_count;
        done_cyc  = t;
      end else if (out_valid) begin
        if (hold_left > 0) begin
          if (hold_left < hold && (out_data !== held || src_ready || tbl_rd)) stable_ok = 1'b0;
          held = out_data;
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = 1'b1;
          got_q.push_back(out_data);
          last_acc = t;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic run(input string tag, input int n, input int hold,
                     input int exp_nb, input logic [7:0] exp_b0, input logic [7:0] exp_b1,
                     input int exp_cnt, input logic exp_err);
    got_q.delete();
    @(negedge clk) encode_start = 1'b1;
    @(negedge clk) encode_start = 1'b0;
    fork
      feed(n);
      collect(hold);
    join
    check({tag, ":done_seen"}, 32'(done_seen), 32'd1);
    check({tag, ":nbytes"}, 32'(got_q.size()), 32'(exp_nb));
    if (got_q.size() > 0) check({tag, ":byte0"}, 32'(got_q[0]), 32'(exp_b0));
    if (got_q.size() > 1) check({tag, ":byte1"}, 32'(got_q[1]), 32'(exp_b1));
    check({tag, ":bit_count"}, 32'(done_cnt), 32'(exp_cnt));
    check({tag, ":err_sym"}, 32'(err_sym), 32'(exp_err));
    if (got_q.size() > 0) check({tag, ":done_lat"}, 32'(done_cyc - last_acc <= 2), 32'd1);
    if (hold > 0) check({tag, ":hold_stable"}, 32'(stable_ok), 32'd1);
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(encode_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h041] = 8'd1; mem[10'h0C1] = 8'h80;
    mem[10'h042] = 8'd3; mem[10'h0C2] = 8'h40;
    mem[10'h010] = 8'd8; mem[10'h090] = 8'hC3;
    mem[10'h020] = 8'd0; mem[10'h0A0] = 8'hFF;
    mem[10'h021] = 8'd2; mem[10'h0A1] = 8'h7F;   // low bits must be masked: code "01"

    reset = 1'b0; encode_start = 1'b0; src_valid = 1'b0; src_data = 8'h00;
    src_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {6'd0, out_valid, src_ready, tbl_rd, encode_done, err_sym, tbl_addr, out_data},
          32'd0);
    check("reset_bit_count", 32'(bit_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    syms = '{8'h41, 8'h42, 8'h41, 8'h42};
    run("t1_aa", 4, 0, 1, 8'hAA, 8'h00, 8, 1'b0);

    syms = '{8'h41, 8'h42, 8'h41, 8'h00};
    run("t2_flush", 3, 0, 1, 8'hA8, 8'h00, 5, 1'b0);

    syms = '{8'h41, 8'h10, 8'h00, 8'h00};
    run("t3_straddle", 2, 0, 2, 8'hE1, 8'h80, 9, 1'b0);

    syms = '{8'h41, 8'h42, 8'h41, 8'h42};
    run("t4_backpressure", 4, 10, 1, 8'hAA, 8'h00, 8, 1'b0);

    syms = '{8'h41, 8'h90, 8'h41, 8'h00};
    run("t5_badsym", 3, 0, 1, 8'hC0, 8'h00, 2, 1'b1);

    syms = '{8'h41, 8'h20, 8'h00, 8'h00};
    run("t5_len0", 2, 0, 1, 8'h80, 8'h00, 1, 1'b1);

    syms = '{8'h21, 8'h21, 8'h00, 8'h00};
    run("t_mask", 2, 0, 1, 8'h50, 8'h00, 4, 1'b0);

    // Reset while a byte is stalled in EMIT.
    syms = '{8'h41, 8'h42, 8'h41, 8'h42};
    out_ready = 1'b0;
    @(negedge clk) encode_start = 1'b1;
    @(negedge clk) encode_start = 1'b0;
    feed(4);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    check("t6_in_emit", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_reset_outputs", {6'd0, out_valid, src_ready, tbl_rd, encode_done, err_sym, tbl_addr, out_data},
          32'd0);
    check("t6_reset_bit_count", 32'(bit_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_idle_after_reset", 32'(out_valid), 32'd0);
    syms = '{8'h41, 8'h42, 8'h41, 8'h00};
    run("t6_rerun", 3, 0, 1, 8'hA8, 8'h00, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
